path_loader: RTL and testbench
==============================

# path_loader

Upstream feeder for the 3x3 grid path-sum engine. Accepts one path from the host as a valid/ready stream: a move count followed by that many 5-bit move codes. It stores the path in a 32x5 register file and serves the engine's combinational read port. It then holds the engine's `start` high until `fin`, captures the 5-bit result, and presents it downstream on a valid/ready output with a watchdog abort.

## Interface
- `TIMEOUT`, default 40: max cycles in RUN without `fin` before abort.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  block accepts host word this cycle.
- `in_data`  in  5  first word of a path = move count N; then N move codes (1=RIGHT, 2=UP, 3=LEFT, 4=DOWN).
- `en`  in  1  engine read enable.
- `addr`  in  5  engine read address.
- `data`  out  5  engine read data.
- `start`  out  1  engine start, level.
- `fin`  in  1  engine done, valid only while `start`=1.
- `result`  in  5  engine path sum, valid when `fin`=1.
- `out_valid`  out  1  captured result available.
- `out_result`  out  5  captured path sum.
- `out_ready`  in  1  downstream accepts result.
- `err`  out  1  one-cycle pulse: length reject or watchdog abort.

## Operation
- Storage: `mem[0..30]` hold moves in arrival order. `mem[31]` holds N.
- `data` = `en` ? `mem[addr]` : 0. The read is purely combinational, with no latency.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On a handshake, write `in_data` to `mem[31]` and clear `wptr`.
    - If `in_data` = 0, go to RUN.
    - If `in_data` > 30, pulse `err` and stay in IDLE; the stored N is not updated.
    - Otherwise go to LOAD.
  - LOAD: `in_ready`=1. Each handshake writes `mem[wptr]` and increments `wptr`. When the handshake with `wptr` = N-1 is accepted, go to RUN.
  - RUN: `start`=1 and `in_ready`=0. A cycle counter starts at 0 on entry.
    - If `fin`=1 at an edge: `out_result` <= `result`, go to DONE.
    - Else if the counter reaches `TIMEOUT`-1: pulse `err`, `out_result` <= 0, go to IDLE.
    - `fin` takes priority over the timeout on the same edge.
  - DONE: `out_valid`=1, `start`=0, `in_ready`=0. On `out_valid`&`out_ready`, go to IDLE.
- Move codes are stored unchecked; code validity is the engine's concern.
- `mem` is not cleared between paths. Only words 0..N-1 and 31 are meaningful.
- `in_data` is ignored when `in_ready`=0. Stored values never change outside a handshake.
- Widths: `wptr` and the compare against N are 5 bits. The watchdog counter is wide enough to reach `TIMEOUT`-1 and saturates there.

## Timing
- Reset values: `in_ready`=1 (IDLE), `start`=0, `out_valid`=0, `out_result`=0, `err`=0. `data` follows `en`/`addr` combinationally; `mem` contents are don't-care.
- Reset asserted mid-LOAD/RUN/DONE: the next cycle is IDLE. `start` drops asynchronously with `rst`, and any pending result is lost.
- Cycle boundaries, with the last move accepted at edge k:
  - `start`=1 from cycle k+1.
  - `start` is still 1 in the cycle where `fin`=1, and is 0 from the following cycle.
  - `out_valid` rises the cycle after the `fin` edge.
- N=0: length accepted at edge k, `start`=1 from cycle k+1.
- Result handshake at edge m: `out_valid`=0 and `in_ready`=1 from cycle m+1. A new length can be accepted at edge m+1.
- `err` is high for exactly one cycle after the offending edge.
- Throughput: one host word per cycle while `in_valid` is held.

## Test plan
- Load N=2, moves 1,4 back-to-back. Check `mem[31]`=2, `mem[0]`=1, `mem[1]`=4 via `en`=1 reads, and `start` rising the cycle after the second move. Engine model asserts `fin`, `result`=3 five cycles later; check `out_valid`=1, `out_result`=3, and `start`=0 next cycle.
- Hold `out_ready`=0 for 4 cycles after result 7. Check `out_valid`/`out_result`=7 stable and `in_valid` words ignored. Assert `out_ready`; check IDLE and `in_ready`=1 next cycle.
- Send length 31. Check `err` one-cycle pulse, state remains IDLE, `mem[31]` unchanged. Then send N=0; check `start` next cycle.
- Engine model never asserts `fin`. Check `err` pulse exactly `TIMEOUT` cycles after `start` rose, `start`=0, `out_valid` never 1, `in_ready`=1.
- Gaps in `in_valid` during LOAD for N=3 (words 2,3,1 with idle cycles between). Check correct storage and `start` only after the third word.
- Assert `rst` during RUN with `start`=1. Check `start`=0 immediately, `out_valid`=0, `in_ready`=1 after release; then a full N=1 path completes normally.

Source files
------------

// File: rtl/path_loader.sv
// path_loader: loads one host path into a 32x5 register file, runs the path-sum engine
// and hands its result downstream, with length reject and watchdog abort.
module path_loader #(
   parameter int TIMEOUT = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] in_data,
   input  logic       en,
   input  logic [4:0] addr,
   output logic [4:0] data,
   output logic       start,
   input  logic       fin,
   input  logic [4:0] result,
   output logic       out_valid,
   output logic [4:0] out_result,
   input  logic       out_ready,
   output logic       err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        state, state_n;
   logic [4:0]    mem [32];
   logic [4:0]    wptr, wptr_n, res_n, waddr;
   logic [CW-1:0] cnt, cnt_n;
   logic          err_n, we, hs_in;

   assign in_ready  = state == IDLE || state == LOAD;
   assign start     = state == RUN;
   assign out_valid = state == DONE;
   assign hs_in     = in_valid && in_ready;
   assign data      = en ? mem[addr] : '0;

   always_comb begin
      state_n = state;
      wptr_n  = wptr;
      cnt_n   = '0;
      res_n   = out_result;
      err_n   = 1'b0;
      we      = 1'b0;
      waddr   = wptr;
      case (state)
         IDLE: if (hs_in) begin
            wptr_n = '0;
            if (in_data > 5'd30) err_n = 1'b1;
            else begin
               we      = 1'b1;
               waddr   = 5'd31;
               state_n = in_data == 5'd0 ? RUN : LOAD;
            end
         end
         LOAD: if (hs_in) begin
            we      = 1'b1;
            wptr_n  = wptr + 5'd1;
            state_n = wptr == mem[31] - 5'd1 ? RUN : LOAD;
         end
         // fin wins over the watchdog when both land on the same edge
         RUN: if (fin) begin
            res_n   = result;
            state_n = DONE;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_n   = 1'b1;
            res_n   = '0;
            state_n = IDLE;
         end else cnt_n = cnt + CW'(1);
         DONE: state_n = out_ready ? IDLE : DONE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wptr       <= '0;
         cnt        <= '0;
         out_result <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         wptr       <= wptr_n;
         cnt        <= cnt_n;
         out_result <= res_n;
         err        <= err_n;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= in_data;
   end
endmodule

// File: tb/tb_path_loader.sv
// tb_path_loader: randomized scenarios against a reference model of the stored path and result.
`timescale 1ns/1ps
module tb_path_loader;
   localparam int TO = 40;

   logic       clk = 0, rst = 1, in_valid = 0, en = 0, fin = 0, out_ready = 0;
   logic [4:0] in_data = 0, addr = 0, result = 0;
   logic       in_ready, start, out_valid, err;
   logic [4:0] data, out_result;

   int         checks = 0, fails = 0;
   logic [4:0] ref_mem [32];
   int         ref_n = -1;

   always #50 clk = ~clk;

   path_loader #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .en(en), .addr(addr), .data(data), .start(start), .fin(fin), .result(result),
      .out_valid(out_valid), .out_result(out_result), .out_ready(out_ready), .err(err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [4:0] a, output logic [4:0] d);
      en = 1; addr = a;
      #1;
      d = data;
      en = 0;
   endtask

   // Sends a length word then its moves; counts cycles where start was already high.
   task automatic load_path(input int n, input logic [4:0] mv[$], input int gmin, input int gmax,
                            output int early);
      early = 0;
      in_valid = 1; in_data = 5'(n);
      if (start) early++;
      tick;
      in_valid = 0;
      if (n <= 30) ref_n = n;
      for (int i = 0; i < (n > 30 ? 0 : n); i++) begin
         repeat ($urandom_range(gmin, gmax)) begin
            if (start) early++;
            tick;
         end
         in_valid = 1; in_data = mv[i];
         ref_mem[i] = mv[i];
         if (start) early++;
         tick;
         in_valid = 0;
      end
   endtask

   task automatic drive_fin(input int d, input logic [4:0] r, output logic st);
      repeat (d) tick;
      fin = 1; result = r;
      st = start;
      tick;
      fin = 0; result = $urandom_range(0, 31);
   endtask

   task automatic rand_moves(input int n, output logic [4:0] q[$]);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(5'($urandom_range(0, 31)));
   endtask

   task automatic test_reset;
      rst = 1;
      #3;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", start); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_result !== 5'd0) begin fails++; $display("FAIL reset_out_result: got %0d want 0", out_result); end
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      tick;
      rst = 0;
      tick;
      checks++; if (in_ready !== 1'b1 || start !== 1'b0) begin fails++; $display("FAIL reset_release: got in_ready=%b start=%b want 1/0", in_ready, start); end
   endtask

   task automatic test_basic;
      logic [4:0] q[$], d;
      int         early;
      logic       st;
      q = '{5'd1, 5'd4};
      load_path(2, q, 0, 0, early);
      checks++; if (early !== 0) begin fails++; $display("FAIL basic_early_start: got %0d cycles want 0", early); end
      checks++; if (start !== 1'b1) begin fails++; $display("FAIL basic_start: got %b want 1", start); end
      peek(5'd31, d);
      checks++; if (d !== 5'(ref_n)) begin fails++; $display("FAIL basic_mem31: got %0d want %0d", d, ref_n); end
      for (int i = 0; i < 2; i++) begin
         peek(5'(i), d);
         checks++; if (d !== ref_mem[i]) begin fails++; $display("FAIL basic_mem%0d: got %0d want %0d", i, d, ref_mem[i]); end
      end
      #1;
      checks++; if (data !== 5'd0) begin fails++; $display("FAIL basic_en_low: got %0d want 0", data); end
      drive_fin(5, 5'd3, st);
      checks++; if (st !== 1'b1) begin fails++; $display("FAIL basic_start_at_fin: got %b want 1", st); end
      checks++; if (out_valid !== 1'b1 || out_result !== 5'd3 || start !== 1'b0) begin fails++; $display("FAIL basic_done: got v=%b r=%0d s=%b want 1/3/0", out_valid, out_result, start); end
      out_ready = 1;
      tick;
      out_ready = 0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_handoff: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_backpressure;
      logic [4:0] q[$], d;
      int         early, n;
      logic       st;
      n = $urandom_range(1, 30);
      rand_moves(n, q);
      load_path(n, q, 0, 0, early);
      drive_fin($urandom_range(0, 10), 5'd7, st);
      for (int c = 0; c < 4; c++) begin
         in_valid = 1; in_data = 5'($urandom_range(0, 31));
         checks++; if (out_valid !== 1'b1 || out_result !== 5'd7 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d: got v=%b r=%0d rdy=%b want 1/7/0", c, out_valid, out_result, in_ready); end
         tick;
      end
      in_valid = 0;
      peek(5'd31, d);
      checks++; if (d !== 5'(ref_n)) begin fails++; $display("FAIL bp_mem31: got %0d want %0d", d, ref_n); end
      for (int i = 0; i < n; i++) begin
         peek(5'(i), d);
         checks++; if (d !== ref_mem[i]) begin fails++; $display("FAIL bp_mem%0d: got %0d want %0d", i, d, ref_mem[i]); end
      end
      out_ready = 1;
      tick;
      out_ready = 0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || start !== 1'b0) begin fails++; $display("FAIL bp_idle: got rdy=%b v=%b s=%b want 1/0/0", in_ready, out_valid, start); end
   endtask

   task automatic test_len_reject;
      logic [4:0] q[$], d;
      int         early, keep, r;
      logic       st;
      keep = ref_n;
      q = {};
      load_path(31, q, 0, 0, early);
      checks++; if (err !== 1'b1 || in_ready !== 1'b1 || start !== 1'b0) begin fails++; $display("FAIL rej_pulse: got err=%b rdy=%b s=%b want 1/1/0", err, in_ready, start); end
      tick;
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL rej_pulse_width: got %b want 0", err); end
      peek(5'd31, d);
      checks++; if (d !== 5'(keep)) begin fails++; $display("FAIL rej_mem31: got %0d want %0d", d, keep); end
      load_path(0, q, 0, 0, early);
      checks++; if (start !== 1'b1) begin fails++; $display("FAIL zero_start: got %b want 1", start); end
      peek(5'd31, d);
      checks++; if (d !== 5'd0) begin fails++; $display("FAIL zero_mem31: got %0d want 0", d); end
      r = $urandom_range(0, 31);
      drive_fin($urandom_range(0, 5), 5'(r), st);
      checks++; if (out_valid !== 1'b1 || out_result !== 5'(r)) begin fails++; $display("FAIL zero_result: got v=%b r=%0d want 1/%0d", out_valid, out_result, r); end
      out_ready = 1;
      tick;
      out_ready = 0;
   endtask

   task automatic test_timeout;
      logic [4:0] q[$];
      int         early, n, i;
      logic       seen;
      n = $urandom_range(1, 30);
      rand_moves(n, q);
      load_path(n, q, 0, 1, early);
      i = 0; seen = 0;
      while (err !== 1'b1 && i < 3 * TO) begin
         seen |= out_valid;
         tick;
         i++;
      end
      checks++; if (i !== TO) begin fails++; $display("FAIL wd_latency: got %0d cycles want %0d", i, TO); end
      checks++; if (start !== 1'b0 || in_ready !== 1'b1 || seen !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL wd_state: got s=%b rdy=%b seen=%b v=%b want 0/1/0/0", start, in_ready, seen, out_valid); end
      checks++; if (out_result !== 5'd0) begin fails++; $display("FAIL wd_result: got %0d want 0", out_result); end
      tick;
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL wd_pulse_width: got %b want 0", err); end
   endtask

   task automatic test_gaps;
      logic [4:0] q[$], d;
      int         early, r;
      logic       st;
      q = '{5'd2, 5'd3, 5'd1};
      load_path(3, q, 1, 3, early);
      checks++; if (early !== 0 || start !== 1'b1) begin fails++; $display("FAIL gaps_start: got early=%0d s=%b want 0/1", early, start); end
      for (int i = 0; i < 3; i++) begin
         peek(5'(i), d);
         checks++; if (d !== ref_mem[i]) begin fails++; $display("FAIL gaps_mem%0d: got %0d want %0d", i, d, ref_mem[i]); end
      end
      peek(5'd31, d);
      checks++; if (d !== 5'd3) begin fails++; $display("FAIL gaps_mem31: got %0d want 3", d); end
      r = $urandom_range(0, 31);
      drive_fin(TO - 1, 5'(r), st);
      checks++; if (out_valid !== 1'b1 || out_result !== 5'(r) || err !== 1'b0) begin fails++; $display("FAIL fin_priority: got v=%b r=%0d err=%b want 1/%0d/0", out_valid, out_result, err, r); end
      out_ready = 1;
      tick;
      out_ready = 0;
   endtask

   task automatic test_reset_run;
      logic [4:0] q[$], d;
      int         early, n, r;
      logic       st;
      n = $urandom_range(1, 30);
      rand_moves(n, q);
      load_path(n, q, 0, 0, early);
      repeat (3) tick;
      checks++; if (start !== 1'b1) begin fails++; $display("FAIL rr_running: got %b want 1", start); end
      rst = 1;
      #1;
      checks++; if (start !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL rr_async: got s=%b v=%b want 0/0", start, out_valid); end
      tick;
      rst = 0;
      tick;
      checks++; if (in_ready !== 1'b1 || start !== 1'b0 || out_valid !== 1'b0 || out_result !== 5'd0) begin fails++; $display("FAIL rr_idle: got rdy=%b s=%b v=%b r=%0d want 1/0/0/0", in_ready, start, out_valid, out_result); end
      rand_moves(1, q);
      load_path(1, q, 0, 0, early);
      checks++; if (early !== 0 || start !== 1'b1) begin fails++; $display("FAIL rr_n1_start: got early=%0d s=%b want 0/1", early, start); end
      peek(5'd0, d);
      checks++; if (d !== ref_mem[0]) begin fails++; $display("FAIL rr_n1_mem0: got %0d want %0d", d, ref_mem[0]); end
      r = $urandom_range(0, 31);
      drive_fin($urandom_range(0, 8), 5'(r), st);
      checks++; if (out_valid !== 1'b1 || out_result !== 5'(r)) begin fails++; $display("FAIL rr_n1_result: got v=%b r=%0d want 1/%0d", out_valid, out_result, r); end
      out_ready = 1;
      tick;
      out_ready = 0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rr_n1_handoff: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_back_to_back;
      logic [4:0] q[$], d;
      int         early, n, r;
      logic       st;
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(0, 30);
         rand_moves(n, q);
         load_path(n, q, 0, it % 3, early);
         checks++; if (early !== 0 || start !== 1'b1) begin fails++; $display("FAIL b2b%0d_start: got early=%0d s=%b want 0/1", it, early, start); end
         peek(5'd31, d);
         checks++; if (d !== 5'(n)) begin fails++; $display("FAIL b2b%0d_mem31: got %0d want %0d", it, d, n); end
         for (int i = 0; i < n; i++) begin
            peek(5'(i), d);
            checks++; if (d !== ref_mem[i]) begin fails++; $display("FAIL b2b%0d_mem%0d: got %0d want %0d", it, i, d, ref_mem[i]); end
         end
         r = $urandom_range(0, 31);
         drive_fin($urandom_range(0, TO - 1), 5'(r), st);
         checks++; if (st !== 1'b1 || out_valid !== 1'b1 || out_result !== 5'(r)) begin fails++; $display("FAIL b2b%0d_result: got s=%b v=%b r=%0d want 1/1/%0d", it, st, out_valid, out_result, r); end
         repeat ($urandom_range(0, 3)) begin
            tick;
            checks++; if (out_valid !== 1'b1 || out_result !== 5'(r)) begin fails++; $display("FAIL b2b%0d_stall: got v=%b r=%0d want 1/%0d", it, out_valid, out_result, r); end
         end
         out_ready = 1;
         tick;
         out_ready = 0;
         checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b%0d_handoff: got rdy=%b v=%b want 1/0", it, in_ready, out_valid); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_len_reject;
      test_timeout;
      test_gaps;
      test_reset_run;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
